// File: rtl/sum_accumulator.sv
// sum_accumulator: groups consecutive sum beats from the upstream adder into
// totals and buffers completed groups in a small ready/valid output FIFO.
module sum_accumulator #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [8:0]               in_sum,
  input  logic [3:0]               cfg_len,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [12:0]              out_total,
  output logic [4:0]               out_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e      state_q, state_d;
  logic [4:0]  len_q, len_d;
  logic [12:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        push;
  logic [12:0] push_total;
  logic [4:0]  push_count;
  logic [4:0]  new_len;
  logic [12:0] acc_sum;
  logic [4:0]  cnt_inc;

  logic [12:0]   total_q [DEPTH];
  logic [4:0]    count_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [7:0]    drop_cnt_q;
  logic          overflow_q;

  logic full, pop, push_ok, drop;

  // Group builder next-state: decides when a group completes and what it carries.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_total = '0;
    push_count = '0;
    new_len    = (cfg_len == 4'd0) ? 5'd16 : {1'b0, cfg_len};
    acc_sum    = acc_q + {4'b0000, in_sum};
    cnt_inc    = cnt_q + 5'd1;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          len_d = new_len;
          // A one-beat group (length 1 or flushed on arrival) never opens ACCUM.
          if (new_len == 5'd1 || flush) begin
            push       = 1'b1;
            push_total = {4'b0000, in_sum};
            push_count = 5'd1;
          end else begin
            state_d = StAccum;
            acc_d   = {4'b0000, in_sum};
            cnt_d   = 5'd1;
          end
        end
      end
      StAccum: begin
        if (in_valid && (cnt_inc == len_q || flush)) begin
          push       = 1'b1;
          push_total = acc_sum;
          push_count = cnt_inc;
          state_d    = StIdle;
          acc_d      = '0;
          cnt_d      = '0;
        end else if (in_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
        end else if (flush) begin
          push       = 1'b1;
          push_total = acc_q;
          push_count = cnt_q;
          state_d    = StIdle;
          acc_d      = '0;
          cnt_d      = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Group builder state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO handshake decode; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    full    = (level_q == LW'(DEPTH));
    pop     = (level_q != '0) && out_ready;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
  end

  // FIFO storage, pointers, occupancy and drop statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        total_q[i] <= '0;
        count_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        total_q[wr_ptr_q] <= push_total;
        count_q[wr_ptr_q] <= push_count;
        wr_ptr_q          <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push_ok) begin
        level_q <= level_q - LW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hff) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

  // Head of FIFO and status outputs.
  always_comb begin
    out_valid = (level_q != '0);
    out_total = total_q[rd_ptr_q];
    out_count = count_q[rd_ptr_q];
    level     = level_q;
    drop_cnt  = drop_cnt_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator (DEPTH = 4).
module tb_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [8:0]  in_sum;
  logic [3:0]  cfg_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_total;
  logic [4:0]  out_count;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int unsigned n_vec;
  int unsigned n_bad;

  sum_accumulator #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .cfg_len   (cfg_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_count (out_count),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input, then sample 1 ns after the edge.
  task automatic step(input logic v, input logic [8:0] s, input logic f);
    in_valid = v;
    in_sum   = s;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum   = '0;
    flush    = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    cfg_len   = 4'd3;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_total", 32'(out_total), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three-beat group, latency one cycle.
    cfg_len = 4'd3;
    step(1'b1, 9'd30, 1'b0);
    step(1'b1, 9'd70, 1'b0);
    check("g3_early", 32'(out_valid), 32'd0);
    step(1'b1, 9'd110, 1'b0);
    check("g3_valid", 32'(out_valid), 32'd1);
    check("g3_total", 32'(out_total), 32'd210);
    check("g3_count", 32'(out_count), 32'd3);
    step(1'b0, 9'd0, 1'b0);
    check("g3_popped", 32'(level), 32'd0);

    // cfg_len 0 means sixteen beats of maximum-ish value.
    cfg_len = 4'd0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 9'd510, 1'b0);
      check("g16_early", 32'(out_valid), 32'd0);
    end
    step(1'b1, 9'd510, 1'b0);
    check("g16_total", 32'(out_total), 32'd8160);
    check("g16_count", 32'(out_count), 32'd16);
    step(1'b0, 9'd0, 1'b0);

    // Single-beat groups with a stalled consumer overflow the FIFO.
    cfg_len   = 4'd1;
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) step(1'b1, 9'(i), 1'b0);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    check("ovf_flag", 32'(overflow), 32'd1);
    step(1'b0, 9'd0, 1'b0);
    check("hold_total", 32'(out_total), 32'd1);
    check("hold_count", 32'(out_count), 32'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_total", 32'(out_total), 32'(k));
      step(1'b0, 9'd0, 1'b0);
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_ovf", 32'(overflow), 32'd1);

    // Flush closes a partial group; the next group runs full length.
    cfg_len = 4'd4;
    step(1'b1, 9'd5, 1'b0);
    step(1'b1, 9'd3, 1'b0);
    step(1'b0, 9'd0, 1'b1);
    check("fl_total", 32'(out_total), 32'd8);
    check("fl_count", 32'(out_count), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 9'd9, 1'b0);
    check("g4_total", 32'(out_total), 32'd36);
    check("g4_count", 32'(out_count), 32'd4);
    step(1'b0, 9'd0, 1'b0);
    // Flush alone in IDLE does nothing; flush with a beat yields a 1-beat group.
    step(1'b0, 9'd0, 1'b1);
    check("fl_idle", 32'(out_valid), 32'd0);
    step(1'b1, 9'd7, 1'b1);
    check("fl1_total", 32'(out_total), 32'd7);
    check("fl1_count", 32'(out_count), 32'd1);
    step(1'b0, 9'd0, 1'b0);

    // Push and pop together while full: no drop, new entry lands last.
    cfg_len   = 4'd1;
    out_ready = 1'b0;
    for (int i = 11; i <= 14; i++) step(1'b1, 9'(i), 1'b0);
    check("full_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    step(1'b1, 9'd15, 1'b0);
    check("pp_level", 32'(level), 32'd4);
    check("pp_drop", 32'(drop_cnt), 32'd2);
    for (int k = 12; k <= 15; k++) begin
      check("pp_order", 32'(out_total), 32'(k));
      step(1'b0, 9'd0, 1'b0);
    end
    check("pp_empty", 32'(out_valid), 32'd0);

    // Reset mid-group discards the partial sum and clears statistics.
    cfg_len = 4'd4;
    step(1'b1, 9'd100, 1'b0);
    step(1'b1, 9'd100, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mr_drop", 32'(drop_cnt), 32'd0);
    check("mr_ovf", 32'(overflow), 32'd0);
    check("mr_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 9'd1, 1'b0);
    step(1'b1, 9'd2, 1'b0);
    step(1'b1, 9'd3, 1'b0);
    check("mr_early", 32'(out_valid), 32'd0);
    step(1'b1, 9'd4, 1'b0);
    check("mr_total", 32'(out_total), 32'd10);
    check("mr_count", 32'(out_count), 32'd4);
    check("mr_level1", 32'(level), 32'd1);
    step(1'b0, 9'd0, 1'b0);
    check("mr_end", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
